intersection_phase_scheduler: RTL
=================================

# intersection_phase_scheduler

Phase sequencer for a two-road (NS/EW) intersection. It drives the vehicle lamps and pedestrian walk lamps for both roads from vehicle-presence sensors and pedestrian push-buttons. Green phases are demand-actuated and bounded by minimum and maximum green times, with fixed yellow and all-red clearance intervals between them. It is the top-level scheduler that shares the intersection between the two traffic_light_control-style signal heads.

## Interface
- MIN_GREEN, 5: minimum green duration in cycles (≥ WALK_TIME, ≥ 1)
- MAX_GREEN, 20: maximum green duration in cycles when conflicting demand exists (≥ MIN_GREEN)
- YELLOW_TIME, 3: yellow duration in cycles (≥ 1)
- ALL_RED_TIME, 2: all-red clearance duration in cycles (≥ 1)
- WALK_TIME, 4: walk lamp duration in cycles (≥ 1)
- TW, 8: phase counter width; must hold MAX_GREEN-1

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- car_ns  in  1  level: vehicle waiting/present on NS
- car_ew  in  1  level: vehicle waiting/present on EW
- ped_req_ns  in  1  one-cycle or longer pulse: pedestrian button for crossing parallel to NS
- ped_req_ew  in  1  same, for EW
- ns_light  out  2  00 red, 01 yellow, 10 green (11 never driven)
- ew_light  out  2  same encoding
- walk_ns  out  1  walk lamp parallel to NS
- walk_ew  out  1  walk lamp parallel to EW
- ped_pending_ns  out  1  NS pedestrian request latched, not yet served
- ped_pending_ew  out  1  EW pedestrian request latched, not yet served
- phase  out  3  current state encoding (0..5, order below)

## Operation
- States: NS_GREEN(0), NS_YELLOW(1), RED_TO_EW(2), EW_GREEN(3), EW_YELLOW(4), RED_TO_NS(5). Fixed cyclic order; no skipping.
- Phase counter cnt: cleared to 0 on every state entry, increments each cycle in state, saturates at MAX_GREEN-1 in green states.
- Lamps: NS_GREEN → ns=10, ew=00; NS_YELLOW → ns=01, ew=00; both red states → 00/00; EW states mirror.
- Pedestrian latch: ped_req_x sets ped_pending_x. It is cleared, and walk_x armed, on entry into X_GREEN. A request asserted in the same cycle as the green entry is captured and served, not left pending. A request arriving during X_GREEN after entry stays pending for the next X_GREEN.
- walk_x = 1 in X_GREEN while armed and cnt < WALK_TIME; 0 in all other states.
- Conflicting demand for NS_GREEN: demand_ew = car_ew | ped_pending_ew (EW symmetric).
- NS_GREEN exits to NS_YELLOW when cnt ≥ MIN_GREEN-1 AND demand_ew AND (!car_ns OR cnt == MAX_GREEN-1).
- With no conflicting demand, green rests indefinitely.
- Demand appearing after saturation causes exit the cycle after the demand is sampled.
- Yellow exits after YELLOW_TIME cycles (cnt == YELLOW_TIME-1). All-red exits after ALL_RED_TIME cycles.
- Reset: phase=NS_GREEN, cnt=0, both pending=0, walk disarmed. Outputs: ns_light=10, ew_light=00, walk_ns=walk_ew=0, phase=0.
- Reset asserted mid-operation overrides all other logic in that cycle, including pending capture and in-progress walk.

## Timing
- All state, counter and latch updates on rising clk. Outputs are decoded from registered state only; there is no combinational path from inputs to outputs.
- Input sampled at edge k affects state/outputs from cycle k+1.
- Green lasts between MIN_GREEN and MAX_GREEN cycles under conflicting demand.
- Yellow lasts exactly YELLOW_TIME cycles; all-red exactly ALL_RED_TIME cycles.
- Minimum full cycle = 2·(MIN_GREEN+YELLOW_TIME+ALL_RED_TIME) = 20 cycles at defaults.
- Lamp conflicts are illegal: ns_light and ew_light are never both non-red; walk_x is never 1 while the crossing road is non-red.

## Test plan
- Reset then car_ew=1, car_ns=0 held: NS green cycles 0–4, NS yellow 5–7, all-red 8–9, EW green from cycle 10.
- car_ns=1 and car_ew=1 held: each green lasts exactly 20 cycles, yellow 3, red 2; period 50 cycles.
- No demand at all for 100 cycles after reset: phase stays 0, ns_light=10, no walk.
- ped_req_ew pulse at cycle 2, no cars: ped_pending_ew=1 from cycle 3; EW green at cycle 10; walk_ew high cycles 10–13; pending cleared at 10.
- ped_req_ns pulse during NS_GREEN at cnt=2 with car_ew=1: no walk this green; pending persists; walk_ns on next NS_GREEN for 4 cycles.
- rst asserted during EW_YELLOW with pending set: next cycle phase=0, ns=10, ew=00, pendings=0, cnt=0. Check the lamp-conflict assertions throughout all scenarios.

Source files
------------

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection phase sequencer: demand-actuated greens bounded by
// min/max green, fixed yellow and all-red clearance, pedestrian walk service.
module intersection_phase_scheduler #(
    parameter int MIN_GREEN    = 5,
    parameter int MAX_GREEN    = 20,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2,
    parameter int WALK_TIME    = 4,
    parameter int TW           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car_ns,
    input  logic       car_ew,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic       ped_pending_ns,
    output logic       ped_pending_ew,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_TO_EW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_TO_NS = 3'd5
    } state_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    localparam logic [TW-1:0] MIN_C  = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_C  = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_C  = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0] RED_C  = TW'(ALL_RED_TIME - 1);
    localparam logic [TW-1:0] WALK_C = TW'(WALK_TIME);

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          pend_ns_q, pend_ns_d;
    logic          pend_ew_q, pend_ew_d;
    logic          arm_ns_q, arm_ns_d;
    logic          arm_ew_q, arm_ew_d;

    logic demand_ns, demand_ew;
    logic exit_now, is_green, enter_ns, enter_ew;

    assign demand_ns = car_ns | pend_ns_q;
    assign demand_ew = car_ew | pend_ew_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= NS_GREEN;
            cnt_q     <= '0;
            pend_ns_q <= 1'b0;
            pend_ew_q <= 1'b0;
            arm_ns_q  <= 1'b0;
            arm_ew_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_ns_q <= pend_ns_d;
            pend_ew_q <= pend_ew_d;
            arm_ns_q  <= arm_ns_d;
            arm_ew_q  <= arm_ew_d;
        end
    end

    always_comb begin
        exit_now = 1'b0;
        is_green = 1'b0;
        state_d  = state_q;
        case (state_q)
            NS_GREEN: begin
                is_green = 1'b1;
                exit_now = (cnt_q >= MIN_C) && demand_ew && (!car_ns || cnt_q == MAX_C);
            end
            EW_GREEN: begin
                is_green = 1'b1;
                exit_now = (cnt_q >= MIN_C) && demand_ns && (!car_ew || cnt_q == MAX_C);
            end
            NS_YELLOW, EW_YELLOW: exit_now = (cnt_q == YEL_C);
            RED_TO_EW, RED_TO_NS: exit_now = (cnt_q == RED_C);
            default:              exit_now = 1'b1;
        endcase

        if (exit_now) begin
            state_d = (state_q == RED_TO_NS || state_q > RED_TO_NS) ? NS_GREEN
                                                                     : state_t'(state_q + 3'd1);
        end

        // Counter saturates only while green so a resting green never wraps.
        if (exit_now)
            cnt_d = '0;
        else if (is_green && cnt_q == MAX_C)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;

        enter_ns = exit_now && (state_q == RED_TO_NS);
        enter_ew = exit_now && (state_q == RED_TO_EW);

        // A request coinciding with green entry is served now, not deferred.
        pend_ns_d = enter_ns ? 1'b0 : (pend_ns_q | ped_req_ns);
        pend_ew_d = enter_ew ? 1'b0 : (pend_ew_q | ped_req_ew);
        arm_ns_d  = enter_ns ? (pend_ns_q | ped_req_ns) : (exit_now ? 1'b0 : arm_ns_q);
        arm_ew_d  = enter_ew ? (pend_ew_q | ped_req_ew) : (exit_now ? 1'b0 : arm_ew_q);
    end

    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        case (state_q)
            NS_GREEN:  ns_light = LAMP_GREEN;
            NS_YELLOW: ns_light = LAMP_YELLOW;
            EW_GREEN:  ew_light = LAMP_GREEN;
            EW_YELLOW: ew_light = LAMP_YELLOW;
            default: ;
        endcase
    end

    assign walk_ns        = (state_q == NS_GREEN) && arm_ns_q && (cnt_q < WALK_C);
    assign walk_ew        = (state_q == EW_GREEN) && arm_ew_q && (cnt_q < WALK_C);
    assign ped_pending_ns = pend_ns_q;
    assign ped_pending_ew = pend_ew_q;
    assign phase          = state_q;

endmodule
